if_fetch_queue: RTL and testbench

//  Instruction-fetch front end: owns the fetch PC, issues in-order requests to a variable-latency

---
 rtl/if_fetch_queue.sv | 198 +++++++++++++++++++
 tb/tb_if_fetch_queue.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
//
// Instruction-fetch front end. Owns the fetch PC and issues in-order requests
// to a variable-latency instruction memory. It buffers {pc, instr} pairs in a
// DEPTH-entry FIFO whose head is presented to the IF/ID register. A decode
// stall holds the head. An EX-stage redirect flushes the FIFO, restarts
// fetching at the redirect target, and discards responses still in flight for
// the wrong path.
//
// Ports
//   clk          in   clock, all state updates on the rising edge
//   reset        in   synchronous, active-low reset
//   redirect     in   EX branch/jump taken: flush and refetch from redirect_pc
//   redirect_pc  in   redirect target byte address
//   stall        in   decode stall: hold the head entry
//   imem_req     out  request valid, accepted in the same cycle (no back-pressure)
//   imem_addr    out  request byte address (current fetch PC)
//   imem_rvalid  in   response valid, returned in request order, latency >= 1
//   imem_rdata   in   response instruction
//   id_valid     out  head entry valid
//   id_pc        out  head entry PC (0 when empty)
//   id_instr     out  head entry instruction (0 when empty)
// ---------------------------------------------------------------------------
module if_fetch_queue #(
  parameter int              PC_W      = 9,
  parameter int              INS_W     = 32,
  parameter int              DEPTH     = 4,
  parameter int              MAX_OUTST = 2,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  input  logic             stall,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_rvalid,
  input  logic [INS_W-1:0] imem_rdata,
  output logic             id_valid,
  output logic [PC_W-1:0]  id_pc,
  output logic [INS_W-1:0] id_instr
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CNT_W  = AW + 1;
  localparam int OUT_W  = $clog2(MAX_OUTST + 1);
  localparam int TAG_AW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  localparam logic [CNT_W:0]    DEPTH_C   = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [OUT_W-1:0]  OUTST_C   = OUT_W'(MAX_OUTST);
  localparam logic [TAG_AW-1:0] TAG_LAST  = TAG_AW'(MAX_OUTST - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DROP
  } state_t;

  state_t            state;
  logic [PC_W-1:0]   fetch_pc;

  // Instruction FIFO
  logic [PC_W-1:0]   fifo_pc    [DEPTH];
  logic [INS_W-1:0]  fifo_instr [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CNT_W-1:0]  count;

  // PCs of outstanding requests, consumed as responses come back in order
  logic [PC_W-1:0]   tag_pc [MAX_OUTST];
  logic [TAG_AW-1:0] tag_wr;
  logic [TAG_AW-1:0] tag_rd;

  logic [OUT_W-1:0]  inflight;
  logic [OUT_W-1:0]  drop_cnt;

  logic              issue;
  logic              push;
  logic              pop;
  logic [CNT_W:0]    credit_used;
  logic [OUT_W-1:0]  inflight_after_rv;

  function automatic logic [TAG_AW-1:0] tag_inc(input logic [TAG_AW-1:0] p);
    return (p == TAG_LAST) ? '0 : p + TAG_AW'(1);
  endfunction

  // Credit counts both buffered entries and requests whose responses are
  // still owed, so a response always finds a free FIFO slot.
  assign credit_used       = (CNT_W + 1)'(count) + (CNT_W + 1)'(inflight);
  assign inflight_after_rv = inflight - OUT_W'(imem_rvalid);

  assign issue = (state != ST_IDLE) && !redirect &&
                 (credit_used < DEPTH_C) && (inflight < OUTST_C);
  // Responses that arrive in DROP, or in the redirect cycle itself, belong
  // to the wrong path and are never written.
  assign push  = imem_rvalid && (state == ST_RUN) && !redirect;
  assign pop   = id_valid && !stall && !redirect;

  assign imem_req  = issue;
  assign imem_addr = fetch_pc;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    id_valid = 1'b0;
    id_pc    = '0;
    id_instr = '0;
    if (count != '0) begin
      id_valid = 1'b1;
      id_pc    = fifo_pc[rd_ptr];
      id_instr = fifo_instr[rd_ptr];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tag_wr   <= '0;
      tag_rd   <= '0;
      inflight <= '0;
      drop_cnt <= '0;
    end else if (redirect) begin
      // Everything still owed by memory after this cycle is wrong-path.
      state    <= (inflight_after_rv != '0) ? ST_DROP : ST_RUN;
      fetch_pc <= redirect_pc;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tag_wr   <= '0;
      tag_rd   <= '0;
      inflight <= inflight_after_rv;
      drop_cnt <= inflight_after_rv;
    end else begin
      case (state)
        ST_IDLE: state <= ST_RUN;
        ST_DROP: begin
          if (imem_rvalid) begin
            drop_cnt <= drop_cnt - OUT_W'(1);
            if (drop_cnt == OUT_W'(1)) state <= ST_RUN;
          end
        end
        default: state <= state;
      endcase

      if (issue) begin
        fetch_pc <= fetch_pc + PC_W'(4);
        tag_wr   <= tag_inc(tag_wr);
      end

      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        tag_rd <= tag_inc(tag_rd);
      end

      if (pop) rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      case ({issue, imem_rvalid})
        2'b10:   inflight <= inflight + OUT_W'(1);
        2'b01:   inflight <= inflight - OUT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // NOTE: storage arrays carry no reset; occupancy is tracked by the reset
  // counters and pointers, and id_* are forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (issue) tag_pc[tag_wr] <= fetch_pc;
    if (push) begin
      fifo_pc[wr_ptr]    <= tag_pc[tag_rd];
      fifo_instr[wr_ptr] <= imem_rdata;
    end
  end

  // A response with nothing outstanding means the memory broke ordering.
  assert property (@(posedge clk) disable iff (!reset)
    imem_rvalid |-> (inflight != '0));

  // The credit rule makes a push into a full FIFO impossible.
  assert property (@(posedge clk) disable iff (!reset)
    push |-> (count != DEPTH_CNT));

endmodule

// File: tb/tb_if_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_queue
//
// Directed bench for if_fetch_queue (PC_W=9, DEPTH=4, MAX_OUTST=2,
// RESET_PC=0). A fixed-latency memory model answers requests in order with
// instr_of(addr). Each step advances one clock, drives the inputs for the new
// cycle, and compares outputs 1 time unit later against hand-traced values.
// ---------------------------------------------------------------------------
module tb_if_fetch_queue;

  localparam int PC_W  = 9;
  localparam int INS_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             redirect;
  logic [PC_W-1:0]  redirect_pc;
  logic             stall;
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_rvalid;
  logic [INS_W-1:0] imem_rdata;
  logic             id_valid;
  logic [PC_W-1:0]  id_pc;
  logic [INS_W-1:0] id_instr;

  int checks = 0;
  int errors = 0;
  int lat    = 1;

  // Memory response pipeline: slot 0 is the response for the current cycle.
  logic            pipe_v [8];
  logic [PC_W-1:0] pipe_a [8];

  always #5 clk = ~clk;

  if_fetch_queue #(
    .PC_W      (PC_W),
    .INS_W     (INS_W),
    .DEPTH     (4),
    .MAX_OUTST (2),
    .RESET_PC  ('0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_instr    (id_instr)
  );

  function automatic logic [INS_W-1:0] instr_of(input logic [PC_W-1:0] a);
    return {7'h55, a, 16'hBEEF};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [PC_W-1:0] pc);
    chk({tag, "_valid"}, 64'(id_valid), 64'(1'b1));
    chk({tag, "_pc"},    64'(id_pc),    64'(pc));
    chk({tag, "_instr"}, 64'(id_instr), 64'(instr_of(pc)));
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [PC_W-1:0] addr);
    chk({tag, "_req"},  64'(imem_req),  64'(req));
    chk({tag, "_addr"}, 64'(imem_addr), 64'(addr));
  endtask

  // One clock: sample the request seen at this edge, then update the memory
  // model so its response is in place for the next cycle.
  task automatic tick();
    logic            req_s;
    logic            rst_s;
    logic [PC_W-1:0] addr_s;
    @(negedge clk);
    req_s  = imem_req;
    addr_s = imem_addr;
    rst_s  = reset;
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) begin
      pipe_v[i] = pipe_v[i+1];
      pipe_a[i] = pipe_a[i+1];
    end
    pipe_v[7] = 1'b0;
    pipe_a[7] = '0;
    if (!rst_s) begin
      for (int i = 0; i < 8; i++) pipe_v[i] = 1'b0;
    end else if (req_s) begin
      pipe_v[lat-1] = 1'b1;
      pipe_a[lat-1] = addr_s;
    end
    imem_rvalid = pipe_v[0];
    imem_rdata  = pipe_v[0] ? instr_of(pipe_a[0]) : '0;
  endtask

  // Leaves the bench in cycle C0: reset just released, DUT in IDLE.
  task automatic do_reset(input int l);
    reset    = 1'b0;
    redirect = 1'b0;
    stall    = 1'b0;
    lat      = l;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("c0_idle", 64'(imem_req), 64'(1'b0));
  endtask

  initial begin
    reset       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    stall       = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;

    // ---- Reset values -----------------------------------------------------
    tick();
    tick();
    #1;
    chk_req("rst", 1'b0, 9'h000);
    chk("rst_valid", 64'(id_valid), 64'(1'b0));
    chk("rst_pc",    64'(id_pc),    64'(0));
    chk("rst_instr", 64'(id_instr), 64'(0));
    reset = 1'b1;
    #1;
    chk("c0_idle", 64'(imem_req), 64'(1'b0));

    // ---- Latency 1, streaming ----------------------------------------------
    tick(); #1; chk_req("l1_c1", 1'b1, 9'h000); chk("l1_c1_v", 64'(id_valid), 64'(1'b0));
    tick(); #1; chk_req("l1_c2", 1'b1, 9'h004); chk("l1_c2_v", 64'(id_valid), 64'(1'b0));
    tick(); #1; chk_req("l1_c3", 1'b1, 9'h008); chk_head("l1_c3", 9'h000);
    tick(); #1; chk_head("l1_c4", 9'h004);
    tick(); #1; chk_head("l1_c5", 9'h008);

    // ---- Stall six cycles at id_pc=8 (C5..C10) ---------------------------
    stall = 1'b1;
    #1;
    chk_req("st_c5", 1'b1, 9'h010);
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      chk_head("st_hold", 9'h008);
      chk("st_req", 64'(imem_req), 64'((i == 0) ? 1'b1 : 1'b0));
    end
    tick();
    stall = 1'b0;
    #1;
    chk_head("st_rel", 9'h008);
    chk("st_rel_req", 64'(imem_req), 64'(1'b0));
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      chk_head("st_drain", 9'(12 + 4 * i));
      if (i == 0) chk_req("st_resume", 1'b1, 9'h018);
    end

    // ---- Latency 3, redirect with two requests in flight ------------------
    do_reset(3);
    tick(); #1; chk_req("l3_c1", 1'b1, 9'h000);
    tick(); #1; chk_req("l3_c2", 1'b1, 9'h004);
    tick(); #1; chk("l3_c3_outst", 64'(imem_req), 64'(1'b0));
    tick(); #1; chk("l3_c4_v", 64'(id_valid), 64'(1'b0));
    tick(); #1; chk_head("l3_c5", 9'h000); chk_req("l3_c5", 1'b1, 9'h008);
    tick(); #1; chk_head("l3_c6", 9'h004); chk_req("l3_c6", 1'b1, 9'h00C);
    tick();
    redirect    = 1'b1;
    redirect_pc = 9'h040;
    #1;
    chk("rd_c7_req", 64'(imem_req), 64'(1'b0));
    tick();
    redirect = 1'b0;
    #1;
    chk("rd_c8_v", 64'(id_valid), 64'(1'b0));
    chk_req("rd_c8", 1'b0, 9'h040);
    tick(); #1; chk_req("rd_c9", 1'b1, 9'h040); chk("rd_c9_v", 64'(id_valid), 64'(1'b0));
    tick(); #1; chk_req("rd_c10", 1'b1, 9'h044);
    tick(); #1; chk("rd_c11_v", 64'(id_valid), 64'(1'b0));
    tick(); #1; chk("rd_c12_v", 64'(id_valid), 64'(1'b0));
    tick(); #1; chk_head("rd_c13", 9'h040);
    tick(); #1; chk_head("rd_c14", 9'h044);

    // ---- Redirect coincident with response and stall ----------------------
    tick(); #1; chk("rs_c15_v", 64'(id_valid), 64'(1'b0)); chk("rs_c15_req", 64'(imem_req), 64'(1'b0));
    tick(); #1; chk("rs_c16_v", 64'(id_valid), 64'(1'b0));
    tick();
    stall = 1'b1;
    #1;
    chk_head("rs_c17", 9'h048);
    chk_req("rs_c17", 1'b1, 9'h050);
    tick(); #1; chk_head("rs_c18", 9'h048); chk_req("rs_c18", 1'b1, 9'h054);
    tick(); #1; chk_head("rs_c19", 9'h048); chk("rs_c19_req", 64'(imem_req), 64'(1'b0));
    tick();
    redirect    = 1'b1;
    redirect_pc = 9'h040;
    #1;
    chk_head("rs_c20", 9'h048);
    chk("rs_c20_req", 64'(imem_req), 64'(1'b0));
    tick();
    redirect = 1'b0;
    stall    = 1'b0;
    #1;
    chk("rs_c21_v", 64'(id_valid), 64'(1'b0));
    chk_req("rs_c21", 1'b1, 9'h040);
    tick(); #1; chk_req("rs_c22", 1'b1, 9'h044); chk("rs_c22_v", 64'(id_valid), 64'(1'b0));
    tick(); #1; chk("rs_c23_v", 64'(id_valid), 64'(1'b0));
    tick(); #1; chk("rs_c24_v", 64'(id_valid), 64'(1'b0));
    tick(); #1; chk_head("rs_c25", 9'h040);
    tick(); #1; chk_head("rs_c26", 9'h044);

    // ---- Redirect to 0x1FC, PC wrap ---------------------------------------
    do_reset(1);
    tick(); #1; chk_req("wr_c1", 1'b1, 9'h000);
    tick();
    redirect    = 1'b1;
    redirect_pc = 9'h1FC;
    #1;
    chk("wr_c2_req", 64'(imem_req), 64'(1'b0));
    tick();
    redirect = 1'b0;
    #1;
    chk_req("wr_c3", 1'b1, 9'h1FC);
    chk("wr_c3_v", 64'(id_valid), 64'(1'b0));
    tick(); #1; chk_req("wr_c4", 1'b1, 9'h000); chk("wr_c4_v", 64'(id_valid), 64'(1'b0));
    tick(); #1; chk_head("wr_c5", 9'h1FC);
    tick(); #1; chk_head("wr_c6", 9'h000);
    tick(); #1; chk_head("wr_c7", 9'h004);

    // ---- Reset mid-DROP with credits exhausted ------------------------------
    do_reset(3);
    stall = 1'b1;
    tick(); #1; chk_req("rm_c1", 1'b1, 9'h000);
    tick(); #1; chk_req("rm_c2", 1'b1, 9'h004);
    tick(); #1; chk("rm_c3_req", 64'(imem_req), 64'(1'b0));
    tick(); #1; chk("rm_c4_v", 64'(id_valid), 64'(1'b0));
    tick(); #1; chk_head("rm_c5", 9'h000); chk_req("rm_c5", 1'b1, 9'h008);
    tick(); #1; chk_head("rm_c6", 9'h000); chk_req("rm_c6", 1'b1, 9'h00C);
    tick();
    redirect    = 1'b1;
    redirect_pc = 9'h100;
    #1;
    chk_head("rm_c7", 9'h000);
    chk("rm_c7_req", 64'(imem_req), 64'(1'b0));
    tick();
    redirect = 1'b0;
    reset    = 1'b0;
    #1;
    chk("rm_c8_v", 64'(id_valid), 64'(1'b0));
    chk_req("rm_c8", 1'b0, 9'h100);
    tick();
    reset = 1'b1;
    stall = 1'b0;
    #1;
    chk("rm_c9_v", 64'(id_valid), 64'(1'b0));
    chk_req("rm_c9", 1'b0, 9'h000);
    tick(); #1; chk_req("rm_c10", 1'b1, 9'h000);
    tick(); #1; chk_req("rm_c11", 1'b1, 9'h004);
    tick(); #1; chk("rm_c12_req", 64'(imem_req), 64'(1'b0));
    tick(); #1; chk("rm_c13_v", 64'(id_valid), 64'(1'b0));
    tick(); #1; chk_head("rm_c14", 9'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
